regfile_read_stage: RTL and testbench
=====================================

# regfile_read_stage

Register-file owner and operand-read stage, sitting between decode and execute; the counterpart of the writeback path. Accepts decoded instructions over a valid/ready handshake and reads rs1/rs2 with same-cycle bypass from the writeback port. Tracks outstanding destination writes in a per-register scoreboard, stalling on RAW/WAW hazards. Absorbs writeback writes (`wb_en/wb_addr/wb_data`) into its 32×32 storage.

## Interface
- `XLEN`, 32: data width.
- `SP_RESET`, 1000: reset value of x2.
- `clk`  in  1  clock; single clock domain, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  decode offers an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_pc`  in  32  instruction PC.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  5 each  register indices.
- `in_rf_wen`  in  1  instruction writes rd.
- `out_valid`  out  1  operands valid for execute.
- `out_ready`  in  1  execute consumes this cycle.
- `out_pc`  out  32  registered PC.
- `out_rs1_data`, `out_rs2_data`  out  XLEN  registered operands.
- `out_rd_addr`  out  5; `out_rf_wen`  out  1  registered destination info.
- `wb_en`  in  1  writeback write strobe.
- `wb_addr`  in  5; `wb_data`  in  XLEN  writeback address/data.
- `flush`  in  1  discard output-register instruction.
- `hazard`  out  1  combinational stall indicator.

## Operation
- Storage: regs[0..31]. x0 reads 0 always; writes to x0 ignored. Write on `wb_en && wb_addr!=0`.
- Read per source s: 0 if addr==0; else `wb_data` if `wb_en && wb_addr==addr`; else regs[addr].
- Scoreboard `pending[31:1]`, one bit per register.
- RAW(s) = addr!=0 && pending[addr] && !(wb_en && wb_addr==addr).
- WAW = in_rf_wen && rd!=0 && pending[rd] && !(wb_en && wb_addr==rd).
- `hazard = in_valid && (RAW(rs1) || RAW(rs2) || WAW)`.
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
- Accept (`in_valid && in_ready`): load out_* with pc, bypassed operands, rd, rf_wen; `out_valid<=1`; if `in_rf_wen && rd!=0` set pending[rd].
- Consume without accept (`out_valid && out_ready`, no accept): `out_valid<=0`; out_* data held.
- Stall (`out_valid && !out_ready`): all out_* stable.
- Writeback clears pending[wb_addr] when `wb_en`, whether or not the bit is set.
- Same-cycle set and clear on same register: set wins.
- Flush: `out_valid<=0`; if out_valid && out_rf_wen && out_rd_addr!=0, clear pending[out_rd_addr]. No accept in a flush cycle. Older in-flight writes keep their bits.
- Operands are captured at accept only; later writebacks do not update a held output.

## Timing
- Reset (`rst_n==0` at edge): regs[2]=SP_RESET, all other regs 0. pending all 0, out_valid 0, out_pc/out_rs*_data 0, out_rd_addr 0, out_rf_wen 0. Reset overrides flush/wb/accept.
- Latency: accept at edge N gives out_valid high after edge N; data visible in cycle N+1.
- Throughput: one instruction per cycle with no hazards and `out_ready` held high.
- Hazard resolution: a writeback in cycle N to a pending source allows accept in cycle N, using bypassed data.
- `in_ready`, `hazard`: combinational from inputs and state. No combinational path from `out_ready` to out_* data.

## Test plan
- Reset: rst_n low 1 cycle. Read x2 -> 1000, x5 -> 0, out_valid 0, pending empty; writes to x0 then reads -> 0.
- Back-to-back independent ops at 1/cycle, out_ready=1. Issue x1<=… (rd=1), then rs1=1 -> hazard=1, in_ready=0 until wb_en addr=1 data=0xDEADBEEF; that cycle accept with out_rs1_data=0xDEADBEEF.
- WAW: rd=3 pending, second rd=3 stalls. wb to x3 same cycle -> accepted, pending[3] remains 1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0. Release -> next instruction loads on that edge.
- Flush while out holds rd=7 with rf_wen=1 -> out_valid 0 next cycle, pending[7]=0, in_ready=0 during flush cycle; later rs1=7 not stalled.
- Reset mid-stream with pending bits set and out_valid=1 -> all cleared next cycle, regs restored (x2=1000).

Source files
------------

// File: rtl/regfile_read_stage_if.sv
// Decode-to-stage and stage-to-execute handshake bundle for the operand-read stage.
// The slave modport is the read stage; master is the surrounding decode/execute side.
interface regfile_read_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_pc;
   logic [4:0]      in_rs1_addr;
   logic [4:0]      in_rs2_addr;
   logic [4:0]      in_rd_addr;
   logic            in_rf_wen;

   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_pc;
   logic [XLEN-1:0] out_rs1_data;
   logic [XLEN-1:0] out_rs2_data;
   logic [4:0]      out_rd_addr;
   logic            out_rf_wen;

   modport master (
      output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rf_wen, out_ready,
      input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_rd_addr, out_rf_wen
   );

   modport slave (
      input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rf_wen, out_ready,
      output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_rd_addr, out_rf_wen
   );
endinterface

// File: rtl/regfile_read_stage.sv
// Register file plus operand-read pipeline stage: bypassed reads from writeback,
// per-register pending scoreboard for RAW/WAW stalls, and a flushable output register.
module regfile_read_stage #(
   parameter int          XLEN     = 32,
   parameter int unsigned SP_RESET = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_read_stage_if.slave  rf_if,
   input  logic                 wb_en,
   input  logic [4:0]           wb_addr,
   input  logic [XLEN-1:0]      wb_data,
   input  logic                 flush,
   output logic                 hazard
);
   logic [XLEN-1:0] regs_q [32];
   logic [31:0]     pending_q, pending_d;

   logic            out_valid_q;
   logic [31:0]     out_pc_q;
   logic [XLEN-1:0] out_rs1_q, out_rs2_q;
   logic [4:0]      out_rd_q;
   logic            out_wen_q;

   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            raw1, raw2, waw, in_ready, accept;

   assign rs1 = rf_if.in_rs1_addr;
   assign rs2 = rf_if.in_rs2_addr;
   assign rd  = rf_if.in_rd_addr;

   always_comb begin
      rs1_val = regs_q[rs1];
      if (rs1 == 5'd0)
         rs1_val = '0;
      else if (wb_en && (wb_addr == rs1))
         rs1_val = wb_data;

      rs2_val = regs_q[rs2];
      if (rs2 == 5'd0)
         rs2_val = '0;
      else if (wb_en && (wb_addr == rs2))
         rs2_val = wb_data;
   end

   // A writeback landing this cycle resolves the hazard it would otherwise cause.
   assign raw1 = (rs1 != 5'd0) && pending_q[rs1] && !(wb_en && (wb_addr == rs1));
   assign raw2 = (rs2 != 5'd0) && pending_q[rs2] && !(wb_en && (wb_addr == rs2));
   assign waw  = rf_if.in_rf_wen && (rd != 5'd0) && pending_q[rd] && !(wb_en && (wb_addr == rd));

   assign hazard   = rf_if.in_valid && (raw1 || raw2 || waw);
   assign in_ready = !flush && !hazard && (!out_valid_q || rf_if.out_ready);
   assign accept   = rf_if.in_valid && in_ready;

   // Clears are applied first so a same-cycle set on the same register wins.
   always_comb begin
      pending_d = pending_q;
      if (wb_en)
         pending_d[wb_addr] = 1'b0;
      if (flush && out_valid_q && out_wen_q)
         pending_d[out_rd_q] = 1'b0;
      if (accept && rf_if.in_rf_wen)
         pending_d[rd] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++)
            regs_q[i] <= (i == 2) ? XLEN'(SP_RESET) : '0;
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         out_rs1_q   <= '0;
         out_rs2_q   <= '0;
         out_rd_q    <= '0;
         out_wen_q   <= 1'b0;
      end else begin
         if (wb_en && (wb_addr != 5'd0))
            regs_q[wb_addr] <= wb_data;
         pending_q <= pending_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= rf_if.in_pc;
            out_rs1_q   <= rs1_val;
            out_rs2_q   <= rs2_val;
            out_rd_q    <= rd;
            out_wen_q   <= rf_if.in_rf_wen;
         end else if (flush || rf_if.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign rf_if.in_ready     = in_ready;
   assign rf_if.out_valid    = out_valid_q;
   assign rf_if.out_pc       = out_pc_q;
   assign rf_if.out_rs1_data = out_rs1_q;
   assign rf_if.out_rs2_data = out_rs2_q;
   assign rf_if.out_rd_addr  = out_rd_q;
   assign rf_if.out_rf_wen   = out_wen_q;
endmodule

// File: tb/tb_regfile_read_stage.sv
// Scenario bench for regfile_read_stage with a register-file/scoreboard reference model.
module tb_regfile_read_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        hazard;

   int checks = 0;
   int errors = 0;

   regfile_read_stage_if #(.XLEN(32)) rf_if ();

   regfile_read_stage #(.XLEN(32), .SP_RESET(1000)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rf_if   (rf_if),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .flush   (flush),
      .hazard  (hazard)
   );

   always #5 clk = ~clk;

   logic [102:0] d_out;
   assign d_out = {rf_if.out_valid, rf_if.out_pc, rf_if.out_rs1_data, rf_if.out_rs2_data,
                   rf_if.out_rd_addr, rf_if.out_rf_wen};

   // Reference model: architectural registers, pending set, and the output slot.
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   logic        m_ov;
   logic [31:0] m_pc, m_rs1, m_rs2;
   logic [4:0]  m_rd;
   logic        m_wen;

   function automatic logic [102:0] m_out();
      return {m_ov, m_pc, m_rs1, m_rs2, m_rd, m_wen};
   endfunction

   function automatic logic wb_hits(input logic [4:0] a);
      return wb_en && (wb_addr == a);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (wb_hits(a)) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic m_hazard();
      logic r1, r2, w;
      r1 = (rf_if.in_rs1_addr != 0) && m_pend[rf_if.in_rs1_addr] && !wb_hits(rf_if.in_rs1_addr);
      r2 = (rf_if.in_rs2_addr != 0) && m_pend[rf_if.in_rs2_addr] && !wb_hits(rf_if.in_rs2_addr);
      w  = rf_if.in_rf_wen && (rf_if.in_rd_addr != 0) && m_pend[rf_if.in_rd_addr] && !wb_hits(rf_if.in_rd_addr);
      return rf_if.in_valid && (r1 || r2 || w);
   endfunction

   function automatic logic m_ready();
      return !flush && !m_hazard() && (!m_ov || rf_if.out_ready);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = (i == 2) ? 32'd1000 : 32'd0;
         m_pend[i] = 1'b0;
      end
      m_ov = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wen = 0;
   endtask

   // Advance one clock edge, updating the model with the inputs held across it.
   task automatic cycle();
      logic        acc;
      logic [31:0] v1, v2;
      acc = rf_if.in_valid && m_ready();
      v1  = m_read(rf_if.in_rs1_addr);
      v2  = m_read(rf_if.in_rs2_addr);
      @(posedge clk);
      if (!rst_n) begin
         m_reset();
      end else begin
         if (wb_en) begin
            if (wb_addr != 0) m_regs[wb_addr] = wb_data;
            m_pend[wb_addr] = 1'b0;
         end
         if (flush) begin
            if (m_ov && m_wen && m_rd != 0) m_pend[m_rd] = 1'b0;
            m_ov = 1'b0;
         end
         if (acc) begin
            m_ov = 1'b1; m_pc = rf_if.in_pc; m_rs1 = v1; m_rs2 = v2;
            m_rd = rf_if.in_rd_addr; m_wen = rf_if.in_rf_wen;
            if (rf_if.in_rf_wen && rf_if.in_rd_addr != 0) m_pend[rf_if.in_rd_addr] = 1'b1;
         end else if (rf_if.out_ready) begin
            m_ov = 1'b0;
         end
      end
      #1;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] d, input logic wen);
      rf_if.in_valid = 1'b1; rf_if.in_pc = pc;
      rf_if.in_rs1_addr = a1; rf_if.in_rs2_addr = a2;
      rf_if.in_rd_addr = d; rf_if.in_rf_wen = wen;
   endtask

   task automatic idle();
      rf_if.in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rf_if.out_ready = 1'b1;
      offer(32'h44, 5'd1, 5'd2, 5'd3, 1'b1);
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h1234_5678; flush = 1'b1;
      cycle();
      checks++;
      if (d_out !== 103'd0) begin errors++; $display("FAIL reset_out got %h exp 0", d_out); end
      checks++;
      if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", hazard); end
      rst_n = 1'b1; idle();
      offer(32'h100, 5'd2, 5'd5, 5'd0, 1'b0);
      #1;
      checks++;
      if (rf_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rf_if.in_ready); end
      cycle();
      checks++;
      if ({rf_if.out_valid, rf_if.out_pc, rf_if.out_rs1_data, rf_if.out_rs2_data} !== {1'b1, 32'h100, 32'd1000, 32'd0}) begin
         errors++; $display("FAIL reset_x2_x5 got %h/%0d/%0d exp 100/1000/0", rf_if.out_pc, rf_if.out_rs1_data, rf_if.out_rs2_data);
      end
      offer(32'h104, 5'd0, 5'd2, 5'd0, 1'b0);
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_0001;
      cycle();
      checks++;
      if (rf_if.out_rs1_data !== 32'd0) begin errors++; $display("FAIL x0_bypass got %h exp 0", rf_if.out_rs1_data); end
      wb_en = 1'b0;
      offer(32'h108, 5'd0, 5'd0, 5'd0, 1'b0);
      cycle();
      checks++;
      if ({rf_if.out_rs1_data, rf_if.out_rs2_data} !== 64'd0) begin
         errors++; $display("FAIL x0_write got %h %h exp 0", rf_if.out_rs1_data, rf_if.out_rs2_data);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      rf_if.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         offer(32'h200 + 32'(4 * i), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 1'b0);
         wb_en = 1'($urandom_range(0, 1)); wb_addr = 5'($urandom_range(0, 31)); wb_data = $urandom;
         #1;
         checks++;
         if (rf_if.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, rf_if.in_ready); end
         cycle();
         checks++;
         if (rf_if.out_pc !== 32'h200 + 32'(4 * i) || d_out !== m_out()) begin
            errors++; $display("FAIL b2b_out[%0d] got %h exp %h", i, d_out, m_out());
         end
      end
      idle();
   endtask

   task automatic test_raw();
      offer(32'h300, 5'd0, 5'd0, 5'd1, 1'b1);
      cycle();
      offer(32'h304, 5'd1, 5'd0, 5'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if ({hazard, rf_if.in_ready} !== 2'b10) begin
            errors++; $display("FAIL raw_stall[%0d] got hz=%b rdy=%b exp hz=1 rdy=0", i, hazard, rf_if.in_ready);
         end
         cycle();
      end
      wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({hazard, rf_if.in_ready} !== 2'b01) begin
         errors++; $display("FAIL raw_resolve got hz=%b rdy=%b exp hz=0 rdy=1", hazard, rf_if.in_ready);
      end
      cycle();
      checks++;
      if ({rf_if.out_valid, rf_if.out_pc, rf_if.out_rs1_data} !== {1'b1, 32'h304, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL raw_bypass got pc=%h rs1=%h exp pc=304 rs1=deadbeef", rf_if.out_pc, rf_if.out_rs1_data);
      end
      idle();
   endtask

   task automatic test_waw();
      offer(32'h400, 5'd0, 5'd0, 5'd3, 1'b1);
      cycle();
      offer(32'h404, 5'd0, 5'd0, 5'd3, 1'b1);
      #1;
      checks++;
      if (hazard !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", hazard); end
      cycle();
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333_0000;
      #1;
      checks++;
      if (rf_if.in_ready !== 1'b1) begin errors++; $display("FAIL waw_resolve got %b exp 1", rf_if.in_ready); end
      cycle();
      checks++;
      if (rf_if.out_pc !== 32'h404) begin errors++; $display("FAIL waw_accept got %h exp 404", rf_if.out_pc); end
      wb_en = 1'b0;
      offer(32'h408, 5'd3, 5'd0, 5'd0, 1'b0);
      #1;
      checks++;
      if (hazard !== 1'b1) begin errors++; $display("FAIL waw_set_wins got %b exp 1", hazard); end
      cycle();
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333_1111;
      cycle();
      checks++;
      if (rf_if.out_rs1_data !== 32'h3333_1111) begin
         errors++; $display("FAIL waw_final got %h exp 33331111", rf_if.out_rs1_data);
      end
      idle();
   endtask

   task automatic test_backpressure();
      rf_if.out_ready = 1'b1;
      offer(32'h500, 5'd2, 5'd1, 5'd0, 1'b0);
      cycle();
      rf_if.out_ready = 1'b0;
      offer(32'h504, 5'd2, 5'd0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         wb_en = 1'b1; wb_addr = 5'd2; wb_data = $urandom;
         #1;
         checks++;
         if (rf_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, rf_if.in_ready); end
         cycle();
         checks++;
         if (rf_if.out_pc !== 32'h500 || rf_if.out_rs1_data !== 32'd1000 || d_out !== m_out()) begin
            errors++; $display("FAIL bp_hold[%0d] got %h exp %h", i, d_out, m_out());
         end
      end
      wb_en = 1'b0; rf_if.out_ready = 1'b1;
      #1;
      checks++;
      if (rf_if.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", rf_if.in_ready); end
      cycle();
      checks++;
      if (rf_if.out_pc !== 32'h504 || d_out !== m_out()) begin
         errors++; $display("FAIL bp_next got %h exp %h", d_out, m_out());
      end
      idle();
   endtask

   task automatic test_flush();
      rf_if.out_ready = 1'b1;
      offer(32'h600, 5'd0, 5'd0, 5'd8, 1'b1);
      cycle();
      offer(32'h604, 5'd0, 5'd0, 5'd7, 1'b1);
      cycle();
      rf_if.out_ready = 1'b0; flush = 1'b1;
      offer(32'h608, 5'd0, 5'd0, 5'd0, 1'b0);
      #1;
      checks++;
      if (rf_if.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", rf_if.in_ready); end
      cycle();
      checks++;
      if (rf_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", rf_if.out_valid); end
      flush = 1'b0;
      offer(32'h60C, 5'd7, 5'd0, 5'd0, 1'b0);
      #1;
      checks++;
      if ({hazard, rf_if.in_ready} !== 2'b01) begin
         errors++; $display("FAIL flush_clear got hz=%b rdy=%b exp hz=0 rdy=1", hazard, rf_if.in_ready);
      end
      cycle();
      checks++;
      if (rf_if.out_pc !== 32'h60C) begin errors++; $display("FAIL flush_after got %h exp 60c", rf_if.out_pc); end
      offer(32'h610, 5'd8, 5'd0, 5'd0, 1'b0);
      #1;
      checks++;
      if (hazard !== 1'b1) begin errors++; $display("FAIL flush_older got %b exp 1", hazard); end
      idle();
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      cycle();
      checks++;
      if (d_out !== 103'd0) begin errors++; $display("FAIL midrst_out got %h exp 0", d_out); end
      rst_n = 1'b1; rf_if.out_ready = 1'b1;
      offer(32'h700, 5'd1, 5'd2, 5'd8, 1'b1);
      #1;
      checks++;
      if (hazard !== 1'b0) begin errors++; $display("FAIL midrst_pending got %b exp 0", hazard); end
      cycle();
      checks++;
      if ({rf_if.out_rs1_data, rf_if.out_rs2_data} !== {32'd0, 32'd1000}) begin
         errors++; $display("FAIL midrst_regs got %h %h exp 0 3e8", rf_if.out_rs1_data, rf_if.out_rs2_data);
      end
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         rf_if.in_valid = 1'($urandom_range(0, 1));
         rf_if.in_pc = $urandom;
         rf_if.in_rs1_addr = 5'($urandom_range(0, 7));
         rf_if.in_rs2_addr = 5'($urandom_range(0, 7));
         rf_if.in_rd_addr = 5'($urandom_range(0, 7));
         rf_if.in_rf_wen = 1'($urandom_range(0, 1));
         rf_if.out_ready = ($urandom_range(0, 3) != 0);
         wb_en = 1'($urandom_range(0, 1));
         wb_addr = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         flush = ($urandom_range(0, 11) == 0);
         #1;
         checks++;
         if ({hazard, rf_if.in_ready} !== {m_hazard(), m_ready()}) begin
            errors++; $display("FAIL rand_comb[%0d] got hz=%b rdy=%b exp hz=%b rdy=%b",
                               i, hazard, rf_if.in_ready, m_hazard(), m_ready());
         end
         cycle();
         checks++;
         if (d_out !== m_out()) begin
            errors++; $display("FAIL rand_out[%0d] got %h exp %h", i, d_out, m_out());
         end
      end
      rst_n = 1'b1;
      idle();
   endtask

   initial begin
      rst_n = 1'b0; rf_if.out_ready = 1'b1; idle();
      rf_if.in_pc = '0; rf_if.in_rs1_addr = '0; rf_if.in_rs2_addr = '0;
      rf_if.in_rd_addr = '0; rf_if.in_rf_wen = 1'b0; wb_addr = '0; wb_data = '0;
      test_reset();
      test_back_to_back();
      test_raw();
      test_waw();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
